// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared types, widths and parity helper for mem_bank_hs
package mem_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int STRB_W     = DEF_DATA_W / 8;

  // Even parity: the stored bit makes the 9-bit group carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_bank_array.sv
// rtl/mem_bank_array.sv - byte-lane writable storage with registered read port
// Per-lane parity storage is present when MEM_BANK_PARITY_EN is defined.
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int LANES  = STRB_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANES-1:0]  we,
  input  logic              re,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_BANK_PARITY_EN
  input  logic              pinv,
`endif
  output logic [DATA_W-1:0] q,
  output logic              perr
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers only raise we/re for in-range addresses.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) q <= mem[addr];
  end

`ifdef MEM_BANK_PARITY_EN
  logic [LANES-1:0] pmem [DEPTH];
  logic [LANES-1:0] pq;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) pmem[addr][i] <= byte_parity(wdata[i*8 +: 8]) ^ pinv;
    end
    if (re) pq <= pmem[addr];
  end

  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (byte_parity(q[i*8 +: 8]) != pq[i]) perr = 1'b1;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/mem_bank_hs.sv
// rtl/mem_bank_hs.sv - handshake single-port RAM: FSM, range check, error logic
// Optional lane parity with perr_inj injection under MEM_BANK_PARITY_EN.
module mem_bank_hs
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  output logic                ready,
  input  logic                wr_rd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
`ifdef MEM_BANK_PARITY_EN
  input  logic                perr_inj,
`endif
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int LANES = DATA_W / 8;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              oor_q, oor_d;

  logic              in_range;
  logic              accept;
  logic [LANES-1:0]  arr_we;
  logic              arr_re;
  logic [DATA_W-1:0] arr_q;
  logic              arr_perr;

  assign in_range = (32'(addr) < DEPTH);
  assign accept   = (state_q == IDLE) && valid && ready_q;
  assign arr_we   = (accept && wr_rd && in_range) ? wstrb : '0;
  assign arr_re   = accept && !wr_rd && in_range;

  mem_bank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_array (
    .clk   (clk),
    .addr  (addr),
    .we    (arr_we),
    .re    (arr_re),
    .wdata (wdata),
`ifdef MEM_BANK_PARITY_EN
    .pinv  (perr_inj),
`endif
    .q     (arr_q),
    .perr  (arr_perr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      oor_q    <= oor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    oor_d    = oor_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          if (wr_rd) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            err_d    = !in_range;
            state_d  = RESP;
          end else begin
            // Only the range verdict of the latched address is needed later.
            oor_d   = !in_range;
            state_d = RD;
          end
        end
      end
      RD: begin
        rvalid_d = 1'b1;
        rdata_d  = oor_q ? '0 : arr_q;
        err_d    = oor_q || arr_perr;
        state_d  = RESP;
      end
      RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          err_d    = 1'b0;
          rdata_d  = '0;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
